// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   sseg_mode_e   : per-digit display mode encodings
//   scan_state_e  : scan FSM states
//   digit_cfg_t   : one digit's shadow/active register contents
//   hex_to_seg    : nibble -> gfedcba pattern
package sseg_pkg;

   typedef enum logic [1:0] {
      MODE_HEX   = 2'd0,
      MODE_RAW   = 2'd1,
      MODE_MINUS = 2'd2,
      MODE_RSVD  = 2'd3
   } sseg_mode_e;

   typedef enum logic [1:0] {
      S_COMMIT = 2'd0,
      S_ON     = 2'd1,
      S_GAP    = 2'd2
   } scan_state_e;

   // Segment bit positions within the 8-bit pattern {dp,g,f,e,d,c,b,a}
   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   localparam logic [6:0] SEG_MINUS = 7'h40;

   typedef struct packed {
      logic       en;
      logic [1:0] mode;
      logic [3:0] val;
      logic [6:0] raw;
      logic       dp;
      logic       blink;
   } digit_cfg_t;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sseg_digit_decoder.sv
// Combinational decode of one digit's configuration into an active-high
// segment pattern.
//   en   : digit enable; 0 blanks everything including dp
//   mode : HEX / RAW / MINUS / reserved (blank)
//   val  : hex nibble for HEX mode
//   raw  : gfedcba pattern for RAW mode
//   dp   : decimal point
//   seg  : {dp,g,f,e,d,c,b,a}, 1 = segment lit
module sseg_digit_decoder
   import sseg_pkg::*;
(
   input  logic       en,
   input  logic [1:0] mode,
   input  logic [3:0] val,
   input  logic [6:0] raw,
   input  logic       dp,
   output logic [7:0] seg
);

   always_comb begin
      seg = '0;
      if (en) begin
         case (sseg_mode_e'(mode))
            MODE_HEX:   seg[SEG_G:SEG_A] = hex_to_seg(val);
            MODE_RAW:   seg[SEG_G:SEG_A] = raw;
            MODE_MINUS: seg[SEG_G:SEG_A] = SEG_MINUS;
            default:    seg[SEG_G:SEG_A] = '0;
         endcase
         seg[SEG_DP] = dp;
      end
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed N-digit seven-segment driver.
// Writes land in per-digit shadow registers; the whole shadow set, brightness
// and prescaler reload are copied into the active set once per frame at
// S_COMMIT, so the display never changes mid-frame. Each digit gets an S_ON
// slot of (led_period+1)*2**PWM_BITS clocks, PWM-dimmed, followed by a
// one-clock S_GAP with all digits off to suppress ghosting.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   wr, sel         : one-clock write strobe and target digit (sel>=SSEG_N ignored)
//   en, mode, val,
//   raw, dp, blink  : digit configuration written to shadow[sel]
//   brightness      : PWM duty, on while pwm_cnt < brightness
//   led_period      : prescaler reload (clocks per PWM step = led_period+1)
//   sseg            : {dp,g,f,e,d,c,b,a} at the pin, polarity per SEG_ACTIVE_LOW
//   oe              : one-hot digit enable at the pin, polarity per OE_ACTIVE_LOW
//   done_tick       : one-clock pulse per frame commit
// All outputs are registered and lag the internal state by one clock.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int unsigned SSEG_N         = 4,
   parameter int unsigned SEL_BITS       = 2,
   parameter int unsigned PWM_BITS       = 4,
   parameter int unsigned PERIOD_BITS    = 8,
   parameter int unsigned BLINK_BITS     = 4,
   parameter bit          SEG_ACTIVE_LOW = 1'b0,
   parameter bit          OE_ACTIVE_LOW  = 1'b0
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr,
   input  logic [SEL_BITS-1:0]    sel,
   input  logic                   en,
   input  logic [1:0]             mode,
   input  logic [3:0]             val,
   input  logic [6:0]             raw,
   input  logic                   dp,
   input  logic                   blink,
   input  logic [PWM_BITS-1:0]    brightness,
   input  logic [PERIOD_BITS-1:0] led_period,
   output logic [7:0]             sseg,
   output logic [SSEG_N-1:0]      oe,
   output logic                   done_tick
);

   scan_state_e state, state_nxt;

   digit_cfg_t shadow [SSEG_N];
   digit_cfg_t active [SSEG_N];
   digit_cfg_t wcfg;
   digit_cfg_t cur;

   logic [PWM_BITS-1:0]    brightness_l;
   logic [PERIOD_BITS-1:0] period_l;
   logic [PERIOD_BITS-1:0] presc;
   logic [PWM_BITS-1:0]    pwm_cnt;
   logic [SEL_BITS-1:0]    digit;
   logic [BLINK_BITS-1:0]  frame_cnt;

   logic                   presc_wrap;
   logic                   slot_end;
   logic                   last_digit;
   logic                   blink_dark;
   logic [7:0]             seg_nxt;
   logic [SSEG_N-1:0]      oe_nxt;
   logic                   done_nxt;

   assign wcfg       = {en, mode, val, raw, dp, blink};
   assign presc_wrap = (presc == period_l);
   assign slot_end   = presc_wrap && (pwm_cnt == '1);
   assign last_digit = (digit == SEL_BITS'(SSEG_N - 1));

   // ---------------- shadow register file ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < SSEG_N; i++) shadow[i] <= '0;
      end else begin
         // Compare against each index so out-of-range sel matches nothing.
         for (int unsigned i = 0; i < SSEG_N; i++)
            if (wr && (sel == SEL_BITS'(i))) shadow[i] <= wcfg;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_COMMIT;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_COMMIT: state_nxt = S_ON;
         S_ON:     if (slot_end) state_nxt = S_GAP;
         S_GAP:    state_nxt = last_digit ? S_COMMIT : S_ON;
         default:  state_nxt = S_COMMIT;
      endcase
   end

   // ---------------- active set, latches and scan counters ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < SSEG_N; i++) active[i] <= '0;
         brightness_l <= '0;
         period_l     <= '0;
         frame_cnt    <= '0;
         digit        <= '0;
         presc        <= '0;
         pwm_cnt      <= '0;
      end else begin
         case (state)
            S_COMMIT: begin
               for (int unsigned i = 0; i < SSEG_N; i++) active[i] <= shadow[i];
               brightness_l <= brightness;
               period_l     <= led_period;
               frame_cnt    <= frame_cnt + 1'b1;
               digit        <= '0;
               presc        <= '0;
               pwm_cnt      <= '0;
            end
            S_ON: begin
               // pwm_cnt wraps to zero at slot end, ready for the next digit.
               if (presc_wrap) begin
                  presc   <= '0;
                  pwm_cnt <= pwm_cnt + 1'b1;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            S_GAP: begin
               if (!last_digit) digit <= digit + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- current digit selection ----------------
   always_comb begin
      cur = '0;
      for (int unsigned i = 0; i < SSEG_N; i++)
         if (digit == SEL_BITS'(i)) cur = active[i];
   end

   assign blink_dark = cur.blink && frame_cnt[BLINK_BITS-1];

   sseg_digit_decoder u_dec (
      .en   (cur.en),
      .mode (cur.mode),
      .val  (cur.val),
      .raw  (cur.raw),
      .dp   (cur.dp),
      .seg  (seg_nxt)
   );

   // ---------------- FSM: outputs ----------------
   always_comb begin
      oe_nxt   = '0;
      done_nxt = (state == S_COMMIT);
      if ((state == S_ON) && (pwm_cnt < brightness_l) && cur.en && !blink_dark) begin
         for (int unsigned i = 0; i < SSEG_N; i++)
            if (digit == SEL_BITS'(i)) oe_nxt[i] = 1'b1;
      end
   end

   // ---------------- output registers (pin polarity applied here) ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sseg      <= {8{SEG_ACTIVE_LOW}};
         oe        <= {SSEG_N{OE_ACTIVE_LOW}};
         done_tick <= 1'b0;
      end else begin
         sseg      <= seg_nxt ^ {8{SEG_ACTIVE_LOW}};
         oe        <= oe_nxt ^ {SSEG_N{OE_ACTIVE_LOW}};
         done_tick <= done_nxt;
      end
   end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Testbench for sseg_scan_ctrl: two instances share all inputs, one with
// active-high pins and one with both pin polarities inverted. Expected pin
// values come from a frame-timing model computed with plain arithmetic.
module tb_sseg_scan_ctrl;

   localparam int N     = 4;
   localparam int SB    = 3;
   localparam int PB    = 2;
   localparam int PRB   = 4;
   localparam int BB    = 2;
   localparam int LP    = 1;
   localparam int SLOT  = (LP + 1) * (1 << PB);
   localparam int FRAME = N * (SLOT + 1) + 1;

   localparam logic [6:0] HEX_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct packed {
      logic       en;
      logic [1:0] mode;
      logic [3:0] val;
      logic [6:0] raw;
      logic       dp;
      logic       blink;
   } tcfg_t;

   typedef struct {
      int          j;
      logic [2:0]  s;
      tcfg_t       c;
   } wr_t;

   logic           clk = 1'b0;
   logic           reset;
   logic           wr;
   logic [SB-1:0]  sel;
   logic           en;
   logic [1:0]     mode;
   logic [3:0]     val;
   logic [6:0]     raw;
   logic           dp;
   logic           blink;
   logic [PB-1:0]  brightness;
   logic [PRB-1:0] led_period;
   logic [7:0]     sseg_a, sseg_b;
   logic [N-1:0]   oe_a, oe_b;
   logic           done_a, done_b;

   tcfg_t shadow_m [N];
   tcfg_t active_m [N];
   tcfg_t snap_m   [N];
   int    fc;
   int    bright_l;
   int    bright_snap;
   int    fno;
   wr_t   wq [$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sseg_scan_ctrl #(
      .SSEG_N(N), .SEL_BITS(SB), .PWM_BITS(PB), .PERIOD_BITS(PRB),
      .BLINK_BITS(BB), .SEG_ACTIVE_LOW(1'b0), .OE_ACTIVE_LOW(1'b0)
   ) dut_a (
      .clk(clk), .reset(reset), .wr(wr), .sel(sel), .en(en), .mode(mode),
      .val(val), .raw(raw), .dp(dp), .blink(blink), .brightness(brightness),
      .led_period(led_period), .sseg(sseg_a), .oe(oe_a), .done_tick(done_a)
   );

   sseg_scan_ctrl #(
      .SSEG_N(N), .SEL_BITS(SB), .PWM_BITS(PB), .PERIOD_BITS(PRB),
      .BLINK_BITS(BB), .SEG_ACTIVE_LOW(1'b1), .OE_ACTIVE_LOW(1'b1)
   ) dut_b (
      .clk(clk), .reset(reset), .wr(wr), .sel(sel), .en(en), .mode(mode),
      .val(val), .raw(raw), .dp(dp), .blink(blink), .brightness(brightness),
      .led_period(led_period), .sseg(sseg_b), .oe(oe_b), .done_tick(done_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_seg(input tcfg_t c);
      logic [6:0] s;
      if (!c.en) return 8'h00;
      case (c.mode)
         2'd0:    s = HEX_TAB[c.val];
         2'd1:    s = c.raw;
         2'd2:    s = 7'h40;
         default: s = 7'h00;
      endcase
      return {c.dp, s};
   endfunction

   // Pin sample j after the done_tick sample reflects internal clock j-1 of the frame.
   function automatic logic [N-1:0] model_oe(input int j);
      logic [N-1:0] r;
      int m, d, r9, step;
      r = '0;
      m = j - 1;
      if (m < 0 || m > N * (SLOT + 1) - 1) return r;
      d    = m / (SLOT + 1);
      r9   = m % (SLOT + 1);
      if (r9 == SLOT) return r;
      step = r9 / (LP + 1);
      if (step < bright_l && active_m[d].en && !(active_m[d].blink && fc >= (1 << (BB - 1))))
         r[d] = 1'b1;
      return r;
   endfunction

   function automatic tcfg_t rand_cfg();
      tcfg_t c;
      c.en    = ($urandom % 4) != 0;
      c.mode  = 2'($urandom);
      c.val   = 4'($urandom);
      c.raw   = 7'($urandom);
      c.dp    = 1'($urandom);
      c.blink = ($urandom % 3) == 0;
      return c;
   endfunction

   function automatic tcfg_t mk(input logic e, input logic [1:0] md, input logic [3:0] v,
                                input logic [6:0] rw, input logic d, input logic b);
      tcfg_t c;
      c.en = e; c.mode = md; c.val = v; c.raw = rw; c.dp = d; c.blink = b;
      return c;
   endfunction

   task automatic push_wr(input int j, input logic [2:0] s, input tcfg_t c);
      wr_t w;
      w.j = j; w.s = s; w.c = c;
      wq.push_back(w);
   endtask

   task automatic check_pins(input int j);
      logic [N-1:0] eo, eo_n;
      logic [7:0]   es, es_n;
      int m;
      eo   = model_oe(j);
      eo_n = ~eo;
      chk($sformatf("oe_a f%0d j%0d", fno, j), 32'(oe_a), 32'(eo));
      chk($sformatf("oe_b f%0d j%0d", fno, j), 32'(oe_b), 32'(eo_n));
      chk($sformatf("done_a f%0d j%0d", fno, j), 32'(done_a), 32'(j == 0));
      chk($sformatf("done_b f%0d j%0d", fno, j), 32'(done_b), 32'(j == 0));
      m = j - 1;
      if (m >= 0 && m < N * (SLOT + 1)) begin
         es   = model_seg(active_m[m / (SLOT + 1)]);
         es_n = ~es;
         chk($sformatf("sseg_a f%0d j%0d", fno, j), 32'(sseg_a), 32'(es));
         chk($sformatf("sseg_b f%0d j%0d", fno, j), 32'(sseg_b), 32'(es_n));
      end
   endtask

   // Entered on the sample where done_tick is high; leaves on the next one.
   task automatic run_frame();
      wr_t w;
      for (int j = 0; j < FRAME; j++) begin
         check_pins(j);
         if (j == FRAME - 1) begin
            for (int k = 0; k < N; k++) snap_m[k] = shadow_m[k];
            bright_snap = int'(brightness);
         end
         wr = 1'b0;
         if (wq.size() > 0 && wq[0].j == j) begin
            w     = wq.pop_front();
            sel   = w.s;
            en    = w.c.en;
            mode  = w.c.mode;
            val   = w.c.val;
            raw   = w.c.raw;
            dp    = w.c.dp;
            blink = w.c.blink;
            wr    = 1'b1;
            if (int'(w.s) < N) shadow_m[w.s] = w.c;
         end
         @(posedge clk); #1;
      end
      wr = 1'b0;
      for (int k = 0; k < N; k++) active_m[k] = snap_m[k];
      fc       = (fc + 1) % (1 << BB);
      bright_l = bright_snap;
      fno++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      int   gap;

      reset = 1'b0; wr = 1'b0; sel = '0; en = 1'b0; mode = '0; val = '0;
      raw = '0; dp = 1'b0; blink = 1'b0; brightness = 2'd3; led_period = 4'(LP);
      fno = 0;
      for (int k = 0; k < N; k++) begin
         shadow_m[k] = '0; active_m[k] = '0;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("reset sseg_a", 32'(sseg_a), 32'h00);
      chk("reset oe_a",   32'(oe_a),   32'h0);
      chk("reset done_a", 32'(done_a), 32'h0);
      chk("reset sseg_b", 32'(sseg_b), 32'hFF);
      chk("reset oe_b",   32'(oe_b),   32'hF);

      @(negedge clk) reset = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done_a) begin found = 1'b1; break; end
      end
      chk("first done_tick", 32'(found), 32'h1);
      fc       = 1;
      bright_l = int'(brightness);

      // F1: all digits blank; hex 3 with dp written to digit 2
      push_wr(2, 3'd2, mk(1'b1, 2'd0, 4'h3, 7'h00, 1'b1, 1'b0));
      run_frame();
      brightness = 2'd1;
      // F2: digit 2 shows 8'hCF; mid-frame MINUS on digit 1, sel=5 ignored,
      // RAW 55 on digit 0 written in the commit cycle
      push_wr(10, 3'd1, mk(1'b1, 2'd2, 4'h0, 7'h00, 1'b0, 1'b0));
      push_wr(20, 3'd5, mk(1'b1, 2'd1, 4'h0, 7'h7F, 1'b1, 1'b0));
      push_wr(FRAME - 1, 3'd0, mk(1'b1, 2'd1, 4'h0, 7'h55, 1'b0, 1'b0));
      run_frame();
      brightness = 2'd0;
      run_frame();                 // F3: brightness 1
      brightness = 2'd3;
      run_frame();                 // F4: brightness 0, fully dark
      // F5..F9: digit 0 blinks, digit 3 steady
      push_wr(3, 3'd0, mk(1'b1, 2'd1, 4'h0, 7'h55, 1'b0, 1'b1));
      push_wr(4, 3'd3, mk(1'b1, 2'd0, 4'hA, 7'h00, 1'b0, 1'b0));
      for (int f = 0; f < 5; f++) run_frame();

      // Randomized frames
      for (int f = 0; f < 5; f++) begin
         for (int k = 0; k < 3; k++)
            push_wr(k * 12 + 1 + int'($urandom % 11), 3'($urandom), rand_cfg());
         brightness = 2'($urandom);
         run_frame();
      end

      // Asynchronous reset mid-frame with digits lit
      brightness = 2'd3;
      for (int k = 0; k < N; k++)
         push_wr(2 + k, 3'(k), mk(1'b1, 2'd0, 4'(k + 5), 7'h00, 1'b0, 1'b0));
      run_frame();
      run_frame();
      for (int j = 0; j < 3; j++) begin
         check_pins(j);
         @(posedge clk); #1;
      end
      chk("pre-reset oe_a", 32'(oe_a), 32'(model_oe(3)));
      reset = 1'b0;
      #1;
      chk("async reset sseg_a", 32'(sseg_a), 32'h00);
      chk("async reset oe_a",   32'(oe_a),   32'h0);
      chk("async reset done_a", 32'(done_a), 32'h0);
      chk("async reset sseg_b", 32'(sseg_b), 32'hFF);
      chk("async reset oe_b",   32'(oe_b),   32'hF);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done_a) begin found = 1'b1; break; end
      end
      chk("done after reset", 32'(found), 32'h1);
      found = 1'b0;
      gap   = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(posedge clk); #1;
         gap++;
         if (done_a) begin found = 1'b1; break; end
         chk($sformatf("cleared oe_a c%0d", gap), 32'(oe_a), 32'h0);
      end
      chk("second done after reset", 32'(found), 32'h1);
      chk("done_tick period", 32'(gap), 32'(FRAME));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
